// File: rtl/fusion_pkg.sv
// Shared definitions for the cmac scheduler slice.
//   DATA_W : operand/result width (fp16)
//   ADDR_W : operand buffer address width
//   LEN_W  : MAC-term count width (kernel_h * kernel_w * channels)
//   sched_state_t : scheduler FSM states
package fusion_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 12;
    localparam int LEN_W  = 12;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ISSUE,
        DRAIN,
        OUTPUT
    } sched_state_t;

endpackage

// File: rtl/cmac_sched_stage.sv
// Two-entry {data, weight} operand FIFO between the buffer read port and the
// cmac operand inputs.
//   clk, rst   : clock, synchronous active-high reset
//   flush      : synchronous empty (used when a new command is accepted)
//   push       : write push_pair (never asserted while full)
//   push_pair  : {data, weight}
//   pop        : drop the head entry (never asserted while empty)
//   count      : number of stored entries, 0..2
//   head       : oldest stored entry
module cmac_sched_stage
    import fusion_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                push,
    input  logic [2*DATA_W-1:0] push_pair,
    input  logic                pop,
    output logic [1:0]          count,
    output logic [2*DATA_W-1:0] head
);

    logic [2*DATA_W-1:0] ent0;
    logic [2*DATA_W-1:0] ent1;
    logic [1:0]          cnt;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            cnt  <= 2'd0;
            ent0 <= '0;
            ent1 <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt == 2'd0) ent0 <= push_pair;
                    else             ent1 <= push_pair;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    ent0 <= ent1;
                    cnt  <= cnt - 2'd1;
                end
                2'b11: begin
                    // Simultaneous push and pop keeps the count; the new pair
                    // lands behind whatever remains after the pop.
                    if (cnt == 2'd1) begin
                        ent0 <= push_pair;
                    end else begin
                        ent0 <= ent1;
                        ent1 <= push_pair;
                    end
                end
                default: ;
            endcase
        end
    end

    assign count = cnt;
    assign head  = ent0;

endmodule

// File: rtl/cmac_sched.sv
// Sequencer for one cmac lane: on start, streams len operand pairs from the
// data/weight buffers into the MAC pipe, counts accumulator completions and
// presents the final sum on a valid/ready port.
//   clk, rst                  : clock, synchronous active-high reset
//   start, len, d_base, w_base: command (sampled in IDLE only)
//   rd_en, d_addr, w_addr     : buffer read request
//   d_rdata, w_rdata          : buffer read data, one cycle after rd_en
//   mac_data/weight/valid     : operands to cmac, mac_ready back-pressure
//   mac_clr                   : accumulator clear pulse
//   acc_rdy, mac_result       : accumulator completion strobe and sum
//   out_data/valid/ready      : result port
//   busy                      : high outside IDLE
// Build option: CMAC_SCHED_RELU_EN clamps negative (sign-set) results to 0.
//
// state  | meaning
// IDLE   | waiting for start
// CLEAR  | one-cycle accumulator clear
// ISSUE  | reading buffers and feeding cmac until len pairs accepted
// DRAIN  | waiting for the remaining acc_rdy pulses
// OUTPUT | holding out_data valid until out_ready
module cmac_sched
    import fusion_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [ADDR_W-1:0] d_base,
    input  logic [ADDR_W-1:0] w_base,
    output logic              rd_en,
    output logic [ADDR_W-1:0] d_addr,
    output logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] d_rdata,
    input  logic [DATA_W-1:0] w_rdata,
    output logic [DATA_W-1:0] mac_data,
    output logic [DATA_W-1:0] mac_weight,
    output logic              mac_valid,
    input  logic              mac_ready,
    output logic              mac_clr,
    input  logic              acc_rdy,
    input  logic [DATA_W-1:0] mac_result,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    sched_state_t        state, state_nx;
    logic [LEN_W-1:0]    len_q, issued, accepted, acc_cnt;
    logic [LEN_W-1:0]    accepted_nx, acc_cnt_nx;
    logic [ADDR_W-1:0]   d_base_q, w_base_q;
    logic                rd_pend;
    logic [1:0]          fifo_cnt;
    logic [2*DATA_W-1:0] fifo_head;
    logic                pop, fifo_push, fifo_pop, fifo_flush, acc_cnt_en, cmd_take;
    logic [2:0]          occ;

    function automatic logic [DATA_W-1:0] capture(input logic [DATA_W-1:0] r);
`ifdef CMAC_SCHED_RELU_EN
        return r[DATA_W-1] ? '0 : r;
`else
        return r;
`endif
    endfunction

    // Fall-through staging: a pair returning from the buffers is visible to
    // cmac in the cycle it arrives, so the in-flight read counts as occupancy.
    assign mac_valid = (fifo_cnt != 2'd0) || rd_pend;
    assign pop       = mac_valid && mac_ready;
    assign fifo_pop  = pop && (fifo_cnt != 2'd0);
    assign fifo_push = rd_pend && !(pop && (fifo_cnt == 2'd0));
    assign occ       = {1'b0, fifo_cnt} + {2'b00, rd_pend} - {2'b00, pop};

    always_comb begin
        {mac_data, mac_weight} = '0;
        if (fifo_cnt != 2'd0) {mac_data, mac_weight} = fifo_head;
        else if (rd_pend)     {mac_data, mac_weight} = {d_rdata, w_rdata};
    end

    assign cmd_take    = (state == IDLE) && start;
    assign fifo_flush  = cmd_take;
    assign rd_en       = (state == ISSUE) && (issued != len_q) && (occ < 3'd2);
    assign d_addr      = d_base_q + ADDR_W'(issued);
    assign w_addr      = w_base_q + ADDR_W'(issued);
    assign acc_cnt_en  = acc_rdy && ((state == ISSUE) || (state == DRAIN));
    assign accepted_nx = pop ? accepted + LEN_ONE : accepted;
    assign acc_cnt_nx  = acc_cnt_en ? acc_cnt + LEN_ONE : acc_cnt;
    assign mac_clr     = (state == CLEAR);
    assign busy        = (state != IDLE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = CLEAR;
            CLEAR:   state_nx = (len_q == '0) ? OUTPUT : ISSUE;
            ISSUE:   if (accepted_nx == len_q) state_nx = DRAIN;
            DRAIN:   if (acc_cnt_nx == len_q) state_nx = OUTPUT;
            OUTPUT:  if (out_valid && out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            len_q     <= '0;
            d_base_q  <= '0;
            w_base_q  <= '0;
            issued    <= '0;
            accepted  <= '0;
            acc_cnt   <= '0;
            rd_pend   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state     <= state_nx;
            rd_pend   <= rd_en;
            out_valid <= (state_nx == OUTPUT);
            if (cmd_take) begin
                len_q    <= len;
                d_base_q <= d_base;
                w_base_q <= w_base;
                issued   <= '0;
                accepted <= '0;
                acc_cnt  <= '0;
            end else begin
                if (rd_en) issued <= issued + LEN_ONE;
                accepted <= accepted_nx;
                acc_cnt  <= acc_cnt_nx;
            end
            if ((state == CLEAR) && (len_q == '0))
                out_data <= '0;
            else if ((state == DRAIN) && (state_nx == OUTPUT))
                out_data <= capture(mac_result);
        end
    end

    cmac_sched_stage u_stage (
        .clk       (clk),
        .rst       (rst),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_pair ({d_rdata, w_rdata}),
        .pop       (fifo_pop),
        .count     (fifo_cnt),
        .head      (fifo_head)
    );

endmodule

// File: tb/tb_cmac_sched.sv
// Self-checking bench for cmac_sched: buffer and accumulator models, an
// address/operand scoreboard checked on every read and every accepted pair,
// a vector table of commands, and a reset-during-issue sequence.
module tb_cmac_sched;

    logic        clk, rst, start;
    logic [11:0] len, d_base, w_base;
    logic        rd_en;
    logic [11:0] d_addr, w_addr;
    logic [15:0] d_rdata, w_rdata;
    logic [15:0] mac_data, mac_weight;
    logic        mac_valid, mac_ready, mac_clr, acc_rdy;
    logic [15:0] mac_result, out_data;
    logic        out_valid, out_ready, busy;

    cmac_sched dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .d_base(d_base), .w_base(w_base),
        .rd_en(rd_en), .d_addr(d_addr), .w_addr(w_addr), .d_rdata(d_rdata), .w_rdata(w_rdata),
        .mac_data(mac_data), .mac_weight(mac_weight), .mac_valid(mac_valid), .mac_ready(mac_ready),
        .mac_clr(mac_clr), .acc_rdy(acc_rdy), .mac_result(mac_result), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] dval(input logic [11:0] a);
        return {4'h1, a};
    endfunction

    function automatic logic [15:0] wval(input logic [11:0] a);
        return {4'h2, a};
    endfunction

    function automatic logic [15:0] relu_exp(input logic [15:0] v);
`ifdef CMAC_SCHED_RELU_EN
        return v[15] ? 16'h0000 : v;
`else
        return v;
`endif
    endfunction

    function automatic logic [15:0] exp_sum(input int n, input logic [11:0] db, input logic [11:0] wb);
        logic [15:0] s;
        logic [11:0] da, wa;
        s = 16'h0;
        for (int i = 0; i < n; i++) begin
            da = db + 12'(i);
            wa = wb + 12'(i);
            s  = s + dval(da) + wval(wa);
        end
        return s;
    endfunction

    // Buffer model: synchronous read, data one cycle after rd_en.
    always @(posedge clk) begin
        if (rd_en) begin
            d_rdata <= dval(d_addr);
            w_rdata <= wval(w_addr);
        end else begin
            d_rdata <= 16'hDEAD;
            w_rdata <= 16'hBEEF;
        end
    end

    // Accumulator model: acc_rdy three cycles after each accepted pair.
    logic [2:0]  pv;
    logic [15:0] pd0, pd1, pd2, acc_sum;
    logic        force_en;
    logic [15:0] force_val;
    always @(posedge clk) begin
        if (rst) begin
            pv      <= 3'b000;
            acc_sum <= 16'h0;
        end else begin
            pv  <= {pv[1:0], mac_valid && mac_ready};
            pd0 <= mac_data + mac_weight;
            pd1 <= pd0;
            pd2 <= pd1;
            if (mac_clr)    acc_sum <= 16'h0;
            else if (pv[2]) acc_sum <= acc_sum + pd2;
        end
    end
    assign acc_rdy    = pv[2];
    assign mac_result = force_en ? force_val : (acc_sum + (pv[2] ? pd2 : 16'h0));

    // Scoreboard / monitor
    logic [23:0] exp_addr_q[$];
    logic [31:0] exp_pair_q[$];
    logic [23:0] ea;
    logic [31:0] ep;
    int mon_reads, mon_acc, mon_occ, first_rd, last_rd, first_mv, last_pop, last_ardy;

    always @(negedge clk) begin
        if (rst) begin
            exp_addr_q.delete();
            exp_pair_q.delete();
        end else begin
            if (rd_en) begin
                mon_occ = mon_reads - mon_acc;
                chk("rd_occupancy_ok", (mon_occ >= 2) && !(mac_valid && mac_ready), 0);
                chk("rd_expected", exp_addr_q.size() != 0, 1);
                if (exp_addr_q.size() != 0) begin
                    ea = exp_addr_q.pop_front();
                    chk("d_addr", d_addr, ea[23:12]);
                    chk("w_addr", w_addr, ea[11:0]);
                end
                if (mon_reads == 0) first_rd = cyc;
                last_rd = cyc;
                mon_reads++;
            end
            if (mac_valid && first_mv < 0) first_mv = cyc;
            if (mac_valid && mac_ready) begin
                chk("pair_expected", exp_pair_q.size() != 0, 1);
                if (exp_pair_q.size() != 0) begin
                    ep = exp_pair_q.pop_front();
                    chk("mac_pair", {mac_data, mac_weight}, ep);
                end
                last_pop = cyc;
                mon_acc++;
            end
            if (acc_rdy) last_ardy = cyc;
        end
    end

    typedef struct {
        int          len;
        logic [11:0] db;
        logic [11:0] wb;
        bit          toggle;
        int          hold;
        bit          force_en;
        logic [15:0] force_val;
        logic [15:0] exp_out;
    } vec_t;

    vec_t vecs[6];

    task automatic mon_clear();
        mon_reads = 0; mon_acc = 0; first_rd = -1; last_rd = -1;
        first_mv = -1; last_pop = -1; last_ardy = -1;
    endtask

    task automatic run_txn(input vec_t v);
        int t0, t_ov;
        bit got;
        logic [11:0] a;
        mon_clear();
        @(posedge clk); #1;
        for (int i = 0; i < v.len; i++) begin
            exp_addr_q.push_back({v.db + 12'(i), v.wb + 12'(i)});
            a = v.db + 12'(i);
            ep = {dval(a), 16'h0};
            a = v.wb + 12'(i);
            ep[15:0] = wval(a);
            exp_pair_q.push_back(ep);
        end
        start = 1'b1; len = 12'(v.len); d_base = v.db; w_base = v.wb;
        out_ready = 1'b0; mac_ready = 1'b1;
        force_en = v.force_en; force_val = v.force_val;
        t0 = cyc;
        @(negedge clk);
        chk("busy_idle_at_start", busy, 0);
        @(posedge clk); #1;
        start = 1'b0;
        len = 12'($urandom); d_base = 12'($urandom); w_base = 12'($urandom);
        @(negedge clk);
        chk("mac_clr_pulse", mac_clr, 1);
        chk("busy_in_clear", busy, 1);
        got = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(posedge clk); #1;
            mac_ready = v.toggle ? (((cyc - t0) % 2) == 0) : 1'b1;
            @(negedge clk);
            if (out_valid) begin
                got = 1'b1;
                break;
            end
        end
        chk("out_valid_seen", got, 1);
        t_ov = cyc;
        chk("out_data", out_data, v.exp_out);
        chk("pairs_accepted", mon_acc, v.len);
        chk("reads_issued", mon_reads, v.len);
        if (v.len == 0) begin
            chk("len0_out_valid_cycle", t_ov - t0, 2);
        end else begin
            chk("out_valid_after_last_acc_rdy", t_ov - last_ardy, 1);
            chk("first_rd_cycle", first_rd - t0, 2);
            chk("first_mac_valid_cycle", first_mv - t0, 3);
            if (!v.toggle) begin
                chk("last_accept_cycle", last_pop - t0, v.len + 2);
                chk("reads_consecutive", last_rd - first_rd, v.len - 1);
            end
        end
        for (int h = 0; h < v.hold; h++) begin
            @(posedge clk); #1;
            start = (h == 1);
            len = 12'd1;
            @(negedge clk);
            chk("hold_out_valid", out_valid, 1);
            chk("hold_out_data", out_data, v.exp_out);
            chk("hold_start_ignored", mac_clr, 0);
        end
        @(posedge clk); #1;
        start = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("handshake_valid", out_valid, 1);
        chk("scoreboard_drained", exp_addr_q.size() + exp_pair_q.size(), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{4, 12'h010, 12'h100, 1'b0, 0, 1'b0, 16'h0, 16'h0};
        vecs[1] = '{6, 12'h020, 12'h200, 1'b1, 0, 1'b0, 16'h0, 16'h0};
        vecs[2] = '{0, 12'h000, 12'h000, 1'b0, 0, 1'b0, 16'h0, 16'h0};
        vecs[3] = '{3, 12'hFFE, 12'h7FF, 1'b0, 0, 1'b0, 16'h0, 16'h0};
        vecs[4] = '{2, 12'h050, 12'h060, 1'b0, 5, 1'b1, 16'hC000, 16'h0};
        vecs[5] = '{2, 12'h123, 12'h456, 1'b0, 0, 1'b0, 16'h0, 16'h0};
        for (int i = 0; i < 6; i++)
            vecs[i].exp_out = vecs[i].force_en ? relu_exp(vecs[i].force_val)
                                               : relu_exp(exp_sum(vecs[i].len, vecs[i].db, vecs[i].wb));

        rst = 1'b1; start = 1'b0; len = 12'h0; d_base = 12'h0; w_base = 12'h0;
        mac_ready = 1'b0; out_ready = 1'b0; force_en = 1'b0; force_val = 16'h0;
        mon_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_d_addr", d_addr, 0);
        chk("rst_w_addr", w_addr, 0);
        chk("rst_mac_valid", mac_valid, 0);
        chk("rst_mac_data", mac_data, 0);
        chk("rst_mac_weight", mac_weight, 0);
        chk("rst_mac_clr", mac_clr, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_txn(vecs[i]);

        // Reset while two pairs sit in staging under mac_ready stall.
        mon_clear();
        @(posedge clk); #1;
        out_ready = 1'b0; mac_ready = 1'b0; force_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_addr_q.push_back({12'h300 + 12'(i), 12'h400 + 12'(i)});
            exp_pair_q.push_back({dval(12'h300 + 12'(i)), wval(12'h400 + 12'(i))});
        end
        start = 1'b1; len = 12'd8; d_base = 12'h300; w_base = 12'h400;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_seq_reads_before_stall", mon_reads, 2);
        chk("rst_seq_mac_valid_buffered", mac_valid, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_seq_busy", busy, 0);
        chk("rst_seq_mac_valid", mac_valid, 0);
        chk("rst_seq_rd_en", rd_en, 0);

        run_txn(vecs[5]);
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("final_busy", busy, 0);
        chk("final_out_valid", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
